// File: rtl/pico_stream_unpack_if.sv
// Pico stream handshake bundle: wide-word input channel
// and narrow-element output channel of the unpacker.
interface pico_stream_unpack_if #(
  parameter int STREAM_W = 128,
  parameter int num_bits = 32
);
  logic                s1i_valid;
  logic                s1i_rdy;
  logic [STREAM_W-1:0] s1i_data;
  logic                s1o_valid;
  logic                s1o_rdy;
  logic [num_bits-1:0] s1o_data;
  logic                s1o_last;

  modport slave (
    input  s1i_valid,
    input  s1i_data,
    output s1i_rdy,
    output s1o_valid,
    output s1o_data,
    output s1o_last,
    input  s1o_rdy
  );

  modport master (
    output s1i_valid,
    output s1i_data,
    input  s1i_rdy,
    input  s1o_valid,
    input  s1o_data,
    input  s1o_last,
    output s1o_rdy
  );
endinterface

// File: rtl/pico_stream_unpack.sv
// Receive-side unpacker: buffers stream words in a FIFO and
// emits them LSB lane first as num_bits elements.
module pico_stream_unpack #(
  parameter int STREAM_W = 128,
  parameter int num_bits = 32,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     clr_count,
  pico_stream_unpack_if.slave      bus,
  output logic [31:0]              count_out,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int LANES = STREAM_W / num_bits;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(LANES);

  logic [STREAM_W-1:0] mem [DEPTH];

  logic [AW-1:0]       wp_q, wp_d;
  logic [AW-1:0]       rp_q, rp_d;
  logic [AW:0]         level_q, level_d;
  logic [STREAM_W-1:0] word_q, word_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic                held_q, held_d;
  logic [31:0]         count_q, count_d;

  logic push, pop, hs, last;

  assign bus.s1i_rdy   = rst_n && (level_q != (AW+1)'(DEPTH))
                         && !flush;
  assign bus.s1o_valid = held_q;
  assign bus.s1o_data  = word_q[lane_q*num_bits +: num_bits];
  assign bus.s1o_last  = held_q && last;
  assign count_out     = count_q;
  assign level         = level_q;

  always_comb begin
    push    = bus.s1i_valid && bus.s1i_rdy;
    hs      = held_q && bus.s1o_rdy;
    last    = (lane_q == LW'(LANES-1));
    pop     = !flush && (level_q != '0)
              && (!held_q || (hs && last));
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    word_d  = word_q;
    lane_d  = lane_q;
    held_d  = held_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      lane_d  = '0;
      held_d  = 1'b0;
    end else begin
      wp_d    = wp_q + AW'(push);
      rp_d    = rp_q + AW'(pop);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      // refill on the last-lane handshake avoids a bubble
      if (pop) begin
        word_d = mem[rp_q];
        lane_d = '0;
        held_d = 1'b1;
      end else if (hs) begin
        if (last) held_d = 1'b0;
        else      lane_d = lane_q + 1'b1;
      end
    end
    count_d = count_q;
    if (clr_count)       count_d = '0;
    else if (hs && !flush) count_d = count_q + 32'd1;
  end

  // storage array carries no reset; validity lives in level_q
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= bus.s1i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      held_q  <= 1'b0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      held_q  <= held_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_pico_stream_unpack.sv
// Randomised bench for pico_stream_unpack against a
// queue-based reference model.
module tb_pico_stream_unpack;
  localparam int SW    = 128;
  localparam int NB    = 32;
  localparam int DEPTH = 4;
  localparam int LANES = SW / NB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        clr_count = 1'b0;
  logic [31:0] count_out;
  logic [2:0]  level;

  pico_stream_unpack_if #(.STREAM_W(SW), .num_bits(NB)) bus();

  pico_stream_unpack #(
    .STREAM_W(SW), .num_bits(NB), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .clr_count(clr_count), .bus(bus),
    .count_out(count_out), .level(level)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [SW-1:0] m_fq[$];
  logic [SW-1:0] m_word = '0;
  bit            m_held = 1'b0;
  int            m_lane = 0;
  logic [31:0]   m_count = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_rdy();
    return rst_n && (m_fq.size() != DEPTH) && !flush;
  endfunction

  task automatic check_outputs();
    chk("s1i_rdy", bus.s1i_rdy, exp_rdy());
    chk("s1o_valid", bus.s1o_valid, m_held);
    chk("s1o_last", bus.s1o_last, m_held && (m_lane == LANES-1));
    chk("level", level, m_fq.size());
    chk("count", count_out, m_count);
    if (m_held)
      chk("s1o_data", bus.s1o_data, m_word[m_lane*NB +: NB]);
  endtask

  // state after the coming rising edge, from the current inputs
  task automatic model_edge();
    bit push, hs, take;
    push = bus.s1i_valid && exp_rdy();
    hs   = m_held && bus.s1o_rdy;
    if (clr_count) m_count = '0;
    else if (hs && !flush) m_count = m_count + 32'd1;
    if (flush) begin
      m_fq.delete();
      m_held = 1'b0;
      m_lane = 0;
    end else begin
      take = (m_fq.size() > 0) &&
             (!m_held || (hs && m_lane == LANES-1));
      if (take) begin
        m_word = m_fq.pop_front();
        m_lane = 0;
        m_held = 1'b1;
      end else if (hs) begin
        if (m_lane == LANES-1) m_held = 1'b0;
        else m_lane++;
      end
      if (push) m_fq.push_back(bus.s1i_data);
    end
  endtask

  task automatic step(bit v, logic [SW-1:0] d, bit f, bit c, bit r);
    @(negedge clk);
    check_outputs();
    bus.s1i_valid = v;
    bus.s1i_data  = d;
    flush         = f;
    clr_count     = c;
    bus.s1o_rdy   = r;
    #1;
    chk("s1i_rdy_now", bus.s1i_rdy, exp_rdy());
    model_edge();
  endtask

  function automatic logic [SW-1:0] rword();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.s1i_valid = 1'b0;
    flush = 1'b0;
    clr_count = 1'b0;
    bus.s1o_rdy = 1'b0;
    #1;
    chk("arst_rdy", bus.s1i_rdy, 0);
    chk("arst_valid", bus.s1o_valid, 0);
    chk("arst_data", bus.s1o_data, 0);
    chk("arst_last", bus.s1o_last, 0);
    chk("arst_count", count_out, 0);
    chk("arst_level", level, 0);
    m_fq.delete();
    m_held = 1'b0;
    m_lane = 0;
    m_count = '0;
    m_word = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 2) != 0, rword(),
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 7);
  endtask

  initial begin
    bus.s1i_valid = 1'b0;
    bus.s1i_data  = '0;
    bus.s1o_rdy   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", bus.s1i_rdy, 0);
    chk("rst_valid", bus.s1o_valid, 0);
    chk("rst_data", bus.s1o_data, 0);
    chk("rst_last", bus.s1o_last, 0);
    chk("rst_count", count_out, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;

    // single word
    step(1, 128'h00000004_00000003_00000002_00000001, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 1);
    @(negedge clk);
    chk("single_cnt", count_out, 32'd4);

    // back-to-back
    for (int i = 0; i < 3; i++) step(1, rword(), 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, '0, 0, 0, 1);
    @(negedge clk);
    chk("b2b_cnt", count_out, 32'd16);

    // backpressure until full, then drain
    for (int i = 0; i < 6; i++) step(1, rword(), 0, 0, 0);
    for (int i = 0; i < 24; i++) step(0, '0, 0, 0, 1);

    // flush with held word at lane 2
    for (int i = 0; i < 3; i++) step(1, rword(), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);

    // count wrap and clear
    step(0, '0, 0, 0, 0);
    dut.count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    step(1, rword(), 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);

    rand_run(1500);
    async_reset();
    rand_run(1500);
    async_reset();
    rand_run(200);
    step(0, '0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
